// File: rtl/dht11_reader_pkg.sv
// Shared definitions for the DHT11 reader and its downstream decoder:
// state encoding, default timing, frame layout and a prescaler width helper.
package dht11_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_DONE
    } dht11_state_t;

    // Default timing, in microseconds unless noted.
    localparam int DEF_CLK_HZ          = 50_000_000;
    localparam int DEF_T_START_US      = 20000;
    localparam int DEF_T_TIMEOUT_US    = 100;
    localparam int DEF_T_BIT_THRESH_US = 40;

    // Frame layout, index 0 = first bit received.
    localparam int FRAME_BITS = 40;
    localparam int RH_INT     = 0;
    localparam int RH_DEC     = 8;
    localparam int T_INT      = 16;
    localparam int T_DEC      = 24;
    localparam int CRC        = 32;

    // Counter widths.
    localparam int US_W  = 15;
    localparam int IDX_W = 6;

    // Prescaler width; never less than one bit so a 1 MHz clock still works.
    function automatic int presc_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/dht11_reader_if.sv
// Request/result bus between the DHT11 reader and the decoder.
// Handshake: the decoder raises start_dht11 (a level); the reader answers with
// wait_dht11 high in that same cycle and keeps it high until sensor_data and
// timeout_err hold the new result. A new read needs start_dht11 to drop and
// rise again; rises while busy are ignored.
interface dht11_reader_if;
    import dht11_reader_pkg::*;

    logic                  start_dht11;
    logic                  wait_dht11;
    logic [0:FRAME_BITS-1] sensor_data;
    logic                  timeout_err;

    modport master (output start_dht11, input wait_dht11, sensor_data, timeout_err);
    modport slave  (input start_dht11, output wait_dht11, sensor_data, timeout_err);

endinterface

// File: rtl/dht11_reader_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every DIV clocks while enabled,
// held at zero phase while disabled.
module us_tick_gen
    import dht11_reader_pkg::*;
#(
    parameter int DIV = 50
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int W = presc_width(DIV);

    logic [W-1:0] cnt;

    // Free-running divide-by-DIV counter, parked at zero when disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                  cnt <= '0;
        else if (!enable)              cnt <= '0;
        else if (cnt == W'(DIV - 1))   cnt <= '0;
        else                           cnt <= cnt + 1'b1;
    end

    assign tick = enable && (cnt == W'(DIV - 1));

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire bus master: drives the start pulse, times the sensor's
// response and 40 data bits on the open-drain line, and returns the frame.
module dht11_reader
    import dht11_reader_pkg::*;
#(
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int T_START_US      = DEF_T_START_US,
    parameter int T_TIMEOUT_US    = DEF_T_TIMEOUT_US,
    parameter int T_BIT_THRESH_US = DEF_T_BIT_THRESH_US
) (
    input  logic          clock,
    input  logic          reset_n,
    inout  wire           dht11_data,
    dht11_reader_if.slave bus
);

    dht11_state_t          state, state_nxt;
    logic [1:0]            sync;
    logic                  line_prev, rise, fall;
    logic                  tick;
    logic [US_W-1:0]       us_count;
    logic [IDX_W-1:0]      bit_idx;
    logic [0:FRAME_BITS-1] shadow, shadow_nxt;
    logic [0:FRAME_BITS-1] data_q;
    logic                  err_q;
    logic                  tmo, finish, abort, drive_low, bit_val;

    us_tick_gen #(.DIV(CLK_HZ / 1_000_000)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state != ST_IDLE),
        .tick    (tick)
    );

    // The host only ever pulls low; otherwise the external pull-up owns the line.
    assign dht11_data = drive_low ? 1'b0 : 1'bz;

    assign rise    = ~line_prev & sync[1];
    assign fall    = line_prev & ~sync[1];
    assign tmo     = us_count >= US_W'(T_TIMEOUT_US);
    assign bit_val = us_count > US_W'(T_BIT_THRESH_US);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; an edge wins over a timeout landing in the same cycle.
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE:      if (bus.start_dht11) state_nxt = ST_START_LOW;
            ST_START_LOW: if (us_count >= US_W'(T_START_US)) state_nxt = ST_RELEASE;
            ST_RELEASE: begin
                if (fall)     state_nxt = ST_RESP_LOW;
                else if (tmo) begin state_nxt = ST_DONE; abort = 1'b1; end
            end
            ST_RESP_LOW: begin
                if (rise)     state_nxt = ST_RESP_HIGH;
                else if (tmo) begin state_nxt = ST_DONE; abort = 1'b1; end
            end
            ST_RESP_HIGH: begin
                if (fall)     state_nxt = ST_BIT_LOW;
                else if (tmo) begin state_nxt = ST_DONE; abort = 1'b1; end
            end
            ST_BIT_LOW: begin
                if (rise)     state_nxt = ST_BIT_HIGH;
                else if (tmo) begin state_nxt = ST_DONE; abort = 1'b1; end
            end
            ST_BIT_HIGH: begin
                if (fall) begin
                    if (bit_idx == IDX_W'(FRAME_BITS - 1)) begin
                        state_nxt = ST_DONE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = ST_BIT_LOW;
                    end
                end else if (tmo) begin
                    state_nxt = ST_DONE;
                    abort     = 1'b1;
                end
            end
            ST_DONE:      if (!bus.start_dht11) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs plus the combinational busy flag the decoder samples.
    always_comb begin
        drive_low      = (state == ST_START_LOW);
        bus.wait_dht11 = reset_n & (((state == ST_IDLE) & bus.start_dht11) |
                                    ((state != ST_IDLE) & (state != ST_DONE)));
    end

    // Line synchronizer and edge history; idles high like the pulled-up line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync      <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync      <= {sync[0], dht11_data};
            line_prev <= sync[1];
        end
    end

    // Phase timer: restarts on every state change. The tick in the transition
    // cycle belongs to the new phase, so an N us phase counts exactly N ticks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                        us_count <= '0;
        else if (state_nxt != state)         us_count <= {{(US_W-1){1'b0}}, tick};
        else if (tick && (us_count != '1))   us_count <= us_count + 1'b1;
    end

    // Bit being captured, folded into the shadow frame on the falling edge.
    always_comb begin
        shadow_nxt = shadow;
        if ((state == ST_BIT_HIGH) && fall) shadow_nxt[bit_idx] = bit_val;
    end

    // Bit index and shadow frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx <= '0;
            shadow  <= '0;
        end else begin
            shadow <= shadow_nxt;
            if ((state == ST_RESP_HIGH) && fall)                          bit_idx <= '0;
            else if ((state == ST_BIT_HIGH) && (state_nxt == ST_BIT_LOW)) bit_idx <= bit_idx + 1'b1;
        end
    end

    // Result registers: only change when DONE is entered or a read starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (finish) begin
            data_q <= shadow_nxt;
            err_q  <= 1'b0;
        end else if (abort) begin
            data_q <= '1;
            err_q  <= 1'b1;
        end else if ((state == ST_IDLE) && bus.start_dht11) begin
            err_q  <= 1'b0;
        end
    end

    assign bus.sensor_data = data_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural DHT11 on a pulled-up line, threshold
// vector table, random frames, reset, missing-sensor and stall cases.
module tb_dht11_reader;
    import dht11_reader_pkg::*;

    localparam int CLK_HZ  = 2_000_000;   // 2 cycles per us
    localparam int CPU     = CLK_HZ / 1_000_000;
    localparam int T_START = 200;
    localparam int T_TMO   = 100;
    localparam int T_TH    = 40;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic sensor_low = 1'b0;
    wire  dht11_data;

    always #5 clock = ~clock;

    pullup (dht11_data);
    assign dht11_data = sensor_low ? 1'b0 : 1'bz;

    dht11_reader_if bus();

    dht11_reader #(
        .CLK_HZ(CLK_HZ), .T_START_US(T_START),
        .T_TIMEOUT_US(T_TMO), .T_BIT_THRESH_US(T_TH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .dht11_data (dht11_data),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;
    int hi_us[40];
    logic [39:0] exp_q[$];

    typedef struct { int hi; logic exp; } thr_vec_t;
    thr_vec_t tv[8];

    // ---------------- checkers ----------------
    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check40(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        total++;
        if (v < lo || v > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, v, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    // A bit is 1 exactly when the sensor held the line high longer than the threshold.
    function automatic logic [39:0] model_frame();
        logic [39:0] f;
        for (int i = 0; i < 40; i++) f[39-i] = (hi_us[i] > T_TH);
        return f;
    endfunction

    task automatic set_hi_from_data(input logic [39:0] d);
        for (int i = 0; i < 40; i++) hi_us[i] = d[39-i] ? 70 : 26;
    endtask

    task automatic set_hi_random();
        for (int i = 0; i < 40; i++) hi_us[i] = $urandom_range(20, 70);
    endtask

    // ---------------- driver helpers ----------------
    task automatic wait_us(input int n);
        repeat (n * CPU) @(negedge clock);
    endtask

    task automatic wait_line(input logic v, input int max_cyc, output int n, output bit ok);
        n = 0;
        while (dht11_data !== v && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        ok = (dht11_data === v);
    endtask

    task automatic count_wait_fall(input int max_cyc, output int n);
        n = 0;
        while (bus.wait_dht11 && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic raise_start(input string tag);
        @(negedge clock);
        bus.start_dht11 = 1'b1;
        #1;
        check1({tag, "_wait_same_cycle"}, bus.wait_dht11, 1'b1);
        check1({tag, "_line_idle_at_start"}, dht11_data, 1'b1);
    endtask

    task automatic drop_start();
        @(negedge clock);
        bus.start_dht11 = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Host start pulse: check it appears and lasts T_START us.
    task automatic observe_start(input string tag, output bit ok);
        int n;
        wait_line(1'b0, 10, n, ok);
        check1({tag, "_start_seen"}, ok, 1'b1);
        if (!ok) return;
        wait_line(1'b1, T_START * CPU + 100, n, ok);
        check_range({tag, "_start_len_cyc"}, n, T_START * CPU - 4, T_START * CPU + 6);
    endtask

    // Behavioural DHT11: ack, response, then 40 bits with hi_us[] high times.
    task automatic sensor_read(input string tag, input int reset_bit, input int stall_after);
        bit ok;
        int n;
        observe_start(tag, ok);
        if (!ok) return;
        wait_us(30);
        sensor_low = 1'b1; wait_us(80);
        sensor_low = 1'b0; wait_us(80);
        for (int i = 0; i < 40; i++) begin
            sensor_low = 1'b1; wait_us(30);
            sensor_low = 1'b0;
            if (i == reset_bit) begin
                wait_us(hi_us[i] / 2);
                check1({tag, "_busy_before_reset"}, bus.wait_dht11, 1'b1);
                bus.start_dht11 = 1'b0;
                reset_n = 1'b0;
                #1;
                check1({tag, "_rst_line_z"}, dht11_data, 1'b1);
                check1({tag, "_rst_wait"}, bus.wait_dht11, 1'b0);
                check40({tag, "_rst_data"}, bus.sensor_data, 40'h0);
                check1({tag, "_rst_err"}, bus.timeout_err, 1'b0);
                repeat (2) @(negedge clock);
                reset_n = 1'b1;
                repeat (2) @(negedge clock);
                check1({tag, "_post_rst_wait"}, bus.wait_dht11, 1'b0);
                check40({tag, "_post_rst_data"}, bus.sensor_data, 40'h0);
                return;
            end
            wait_us(hi_us[i]);
            if (i == stall_after) begin
                sensor_low = 1'b1;
                return;
            end
        end
        check1({tag, "_busy_at_last_fall"}, bus.wait_dht11, 1'b1);
        sensor_low = 1'b1;
        count_wait_fall(20, n);
        check_range({tag, "_wait_fall_lat"}, n, 2, 4);
        wait_us(30);
        sensor_low = 1'b0;
    endtask

    // Complete read against the scoreboard.
    task automatic full_read(input string tag);
        logic [39:0] e;
        exp_q.push_back(model_frame());
        raise_start(tag);
        sensor_read(tag, -1, -1);
        e = exp_q.pop_front();
        check1({tag, "_wait_done"}, bus.wait_dht11, 1'b0);
        check40({tag, "_data"}, bus.sensor_data, e);
        check1({tag, "_err"}, bus.timeout_err, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, lows, busy;
        bit ok;

        tv[0] = '{26, 1'b0}; tv[1] = '{70, 1'b1}; tv[2] = '{40, 1'b0}; tv[3] = '{41, 1'b1};
        tv[4] = '{39, 1'b0}; tv[5] = '{45, 1'b1}; tv[6] = '{20, 1'b0}; tv[7] = '{42, 1'b1};

        bus.start_dht11 = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check1("reset_wait", bus.wait_dht11, 1'b0);
        check40("reset_data", bus.sensor_data, 40'h0);
        check1("reset_err", bus.timeout_err, 1'b0);
        check1("reset_line", dht11_data, 1'b1);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Valid read of a known frame.
        set_hi_from_data(40'h3700190050);
        full_read("valid");
        check40("valid_literal", bus.sensor_data, 40'h3700190050);

        // Request held high after DONE must not retrigger.
        lows = 0; busy = 0;
        repeat (300 * CPU) begin
            @(negedge clock);
            if (dht11_data === 1'b0) lows++;
            if (bus.wait_dht11) busy++;
        end
        check_range("hold_no_restart_lows", lows, 0, 0);
        check_range("hold_no_busy", busy, 0, 0);
        drop_start();
        check1("idle_after_drop", bus.wait_dht11, 1'b0);

        // Threshold vectors across the 40 bits.
        for (int i = 0; i < 40; i++) hi_us[i] = tv[i % 8].hi;
        full_read("thresh");
        for (int i = 0; i < 40; i++)
            check1($sformatf("thr_bit%0d_hi%0d", i, tv[i % 8].hi), bus.sensor_data[i], tv[i % 8].exp);
        drop_start();

        // No sensor: line never acknowledged.
        raise_start("nosens");
        observe_start("nosens", ok);
        count_wait_fall(400, n);
        check_range("nosens_tmo_cyc", n, T_TMO * CPU - 4, T_TMO * CPU + 6);
        check40("nosens_data", bus.sensor_data, 40'hFF_FFFF_FFFF);
        check1("nosens_err", bus.timeout_err, 1'b1);
        check1("nosens_wait", bus.wait_dht11, 1'b0);
        drop_start();

        // Random frames; also clears the sticky error.
        for (int r = 0; r < 2; r++) begin
            set_hi_random();
            full_read($sformatf("rand%0d", r));
            drop_start();
        end

        // Reset during bit 17, then a normal read.
        set_hi_random();
        raise_start("rst");
        sensor_read("rst", 17, -1);
        set_hi_random();
        full_read("after_rst");
        drop_start();

        // Sensor stalls low after bit 20.
        set_hi_random();
        raise_start("stall");
        sensor_read("stall", -1, 20);
        count_wait_fall(600, n);
        check_range("stall_tmo_cyc", n, T_TMO * CPU - 4, T_TMO * CPU + 12);
        check40("stall_data", bus.sensor_data, 40'hFF_FFFF_FFFF);
        check1("stall_err", bus.timeout_err, 1'b1);
        check1("stall_wait", bus.wait_dht11, 1'b0);
        sensor_low = 1'b0;
        drop_start();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hang guard.
    initial begin
        #1_400_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
